// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory req/ack and accelerator-bus valid/ready transactions,
// upstream stall generation and the MEM/WB register. Optional watchdog: MEM_TIMEOUT_EN.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] iAluOut,
    input  logic [15:0] iData2,
    input  logic [3:0]  iDest,
    input  logic        iAlutoReg,
    input  logic        iMemtoReg,
    input  logic        iBustoReg,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic        iBusWrite,
    output logic        oStall,
    output logic        oDmReq,
    output logic        oDmWe,
    output logic [15:0] oDmAddr,
    output logic [15:0] oDmWdata,
    input  logic        iDmAck,
    input  logic [15:0] iDmRdata,
    output logic        oBusValid,
    output logic        oBusWe,
    output logic [7:0]  oBusAddr,
    output logic [15:0] oBusWdata,
    input  logic        iBusReady,
    input  logic [15:0] iBusRdata,
    output logic [15:0] oWbData,
    output logic [3:0]  oDest,
    output logic        oRegWrite,
    output logic        oErr
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MEM_REQ = 2'd1;
    localparam logic [1:0] BUS_REQ = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [15:0] mem_rdata_q, mem_rdata_d;
    logic [15:0] bus_rdata_q, bus_rdata_d;
    logic [15:0] wb_data_q, wb_data_d;
    logic [3:0]  dest_q, dest_d;
    logic        reg_write_q, reg_write_d;

    logic mem_op, bus_op, stall, in_req, timeout_fire;

    assign mem_op = iMemRead | iMemWrite;
    assign bus_op = iBusWrite | iBustoReg;
    assign in_req = (state_q == MEM_REQ) || (state_q == BUS_REQ);

    // Gated by rst_n so a reset mid-transaction releases the upstream pipeline at once.
    assign stall = rst_n & ((state_q == IDLE) ? (mem_op | bus_op) : in_req);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            cnt_hit;

    assign cnt_hit = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    // A response arriving in the expiry cycle takes precedence over the timeout.
    assign timeout_fire = cnt_hit & (((state_q == MEM_REQ) & ~iDmAck) |
                                     ((state_q == BUS_REQ) & ~iBusReady));

    always_comb begin
        cnt_d = '0;
        if (in_req) begin
            cnt_d = cnt_q + 1'b1;
        end
        err_d = err_q | timeout_fire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign oErr = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_fire   = 1'b0;
    assign oErr           = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        mem_rdata_d = mem_rdata_q;
        bus_rdata_d = bus_rdata_q;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    addr_d  = iAluOut;
                    wdata_d = iData2;
                    we_d    = iMemWrite;
                    state_d = MEM_REQ;
                end else if (bus_op) begin
                    addr_d  = iAluOut;
                    wdata_d = iData2;
                    we_d    = iBusWrite;
                    state_d = BUS_REQ;
                end
            end
            MEM_REQ: begin
                if (iDmAck) begin
                    mem_rdata_d = iDmRdata;
                    state_d     = DONE;
                end else if (timeout_fire) begin
                    mem_rdata_d = 16'hDEAD;
                    state_d     = DONE;
                end
            end
            BUS_REQ: begin
                if (iBusReady) begin
                    bus_rdata_d = iBusRdata;
                    state_d     = DONE;
                end else if (timeout_fire) begin
                    bus_rdata_d = 16'hDEAD;
                    state_d     = DONE;
                end
            end
            // Inputs still hold the finished op here; never re-trigger from DONE.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wb_data_d   = wb_data_q;
        dest_d      = dest_q;
        reg_write_d = 1'b0;
        if (!stall) begin
            dest_d      = iDest;
            reg_write_d = iAlutoReg | iMemtoReg | iBustoReg;
            if (iMemtoReg) begin
                wb_data_d = mem_rdata_q;
            end else if (iBustoReg) begin
                wb_data_d = bus_rdata_q;
            end else begin
                wb_data_d = iAluOut;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            mem_rdata_q <= '0;
            bus_rdata_q <= '0;
            wb_data_q   <= '0;
            dest_q      <= '0;
            reg_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            mem_rdata_q <= mem_rdata_d;
            bus_rdata_q <= bus_rdata_d;
            wb_data_q   <= wb_data_d;
            dest_q      <= dest_d;
            reg_write_q <= reg_write_d;
        end
    end

    assign oStall    = stall;
    assign oDmReq    = (state_q == MEM_REQ);
    assign oDmWe     = oDmReq & we_q;
    assign oDmAddr   = addr_q;
    assign oDmWdata  = wdata_q;
    assign oBusValid = (state_q == BUS_REQ);
    assign oBusWe    = oBusValid & we_q;
    assign oBusAddr  = addr_q[7:0];
    assign oBusWdata = wdata_q;
    assign oWbData   = wb_data_q;
    assign oDest     = dest_q;
    assign oRegWrite = reg_write_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected transactions and write-backs,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_stage;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] iAluOut, iData2;
    logic [3:0]  iDest;
    logic        iAlutoReg, iMemtoReg, iBustoReg, iMemRead, iMemWrite, iBusWrite;
    logic        oStall, oDmReq, oDmWe, iDmAck;
    logic [15:0] oDmAddr, oDmWdata, iDmRdata;
    logic        oBusValid, oBusWe, iBusReady;
    logic [7:0]  oBusAddr;
    logic [15:0] oBusWdata, iBusRdata, oWbData;
    logic [3:0]  oDest;
    logic        oRegWrite, oErr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [19:0] wb_q[$];   // {data, dest}
    logic [32:0] dm_q[$];   // {addr, we, wdata}
    logic [24:0] bus_q[$];  // {addr8, we, wdata}

    mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .iAluOut(iAluOut), .iData2(iData2), .iDest(iDest),
        .iAlutoReg(iAlutoReg), .iMemtoReg(iMemtoReg), .iBustoReg(iBustoReg),
        .iMemRead(iMemRead), .iMemWrite(iMemWrite), .iBusWrite(iBusWrite),
        .oStall(oStall),
        .oDmReq(oDmReq), .oDmWe(oDmWe), .oDmAddr(oDmAddr), .oDmWdata(oDmWdata),
        .iDmAck(iDmAck), .iDmRdata(iDmRdata),
        .oBusValid(oBusValid), .oBusWe(oBusWe), .oBusAddr(oBusAddr), .oBusWdata(oBusWdata),
        .iBusReady(iBusReady), .iBusRdata(iBusRdata),
        .oWbData(oWbData), .oDest(oDest), .oRegWrite(oRegWrite), .oErr(oErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the scoreboard heads.
    always @(negedge clk) begin
        if (rst_n) begin
            if (oRegWrite) begin
                if (wb_q.size() == 0) check("wb_unexpected", {44'd0, oWbData, oDest}, 64'd0);
                else check("wb", {44'd0, oWbData, oDest}, {44'd0, wb_q.pop_front()});
            end
            if (oDmReq) begin
                if (dm_q.size() == 0) check("dm_unexpected", {31'd0, oDmAddr, oDmWe, oDmWdata}, 64'd0);
                else begin
                    check("dm", {31'd0, oDmAddr, oDmWe, oDmWdata}, {31'd0, dm_q[0]});
                    if (iDmAck) void'(dm_q.pop_front());
                end
            end
            if (oBusValid) begin
                if (bus_q.size() == 0) check("bus_unexpected", {39'd0, oBusAddr, oBusWe, oBusWdata}, 64'd0);
                else begin
                    check("bus", {39'd0, oBusAddr, oBusWe, oBusWdata}, {39'd0, bus_q[0]});
                    if (iBusReady) void'(bus_q.pop_front());
                end
            end
        end
    end

    task automatic clear_inputs();
        iAluOut = '0; iData2 = '0; iDest = '0;
        iAlutoReg = 0; iMemtoReg = 0; iBustoReg = 0;
        iMemRead = 0; iMemWrite = 0; iBusWrite = 0;
        iDmAck = 0; iBusReady = 0; iDmRdata = '0; iBusRdata = '0;
    endtask

    // Called at posedge+2; returns at posedge+2 of the cycle after the op leaves the stage.
    task automatic run_op(input string name, input logic [15:0] alu, input logic [15:0] d2,
                          input logic [3:0] dest, input logic a2r, input logic m2r,
                          input logic b2r, input logic mr, input logic mw, input logic bw,
                          input int waits, input logic [15:0] rdata, input logic [15:0] exp_wb,
                          input int exp_stall, input int exp_req);
        int  stalls = 0;
        int  reqs   = 0;
        bit  done   = 0;
        iAluOut = alu; iData2 = d2; iDest = dest;
        iAlutoReg = a2r; iMemtoReg = m2r; iBustoReg = b2r;
        iMemRead = mr; iMemWrite = mw; iBusWrite = bw;
        if (a2r | m2r | b2r) wb_q.push_back({exp_wb, dest});
        if (mr | mw) dm_q.push_back({alu, mw, d2});
        else if (bw | b2r) bus_q.push_back({alu[7:0], bw, d2});
        for (int c = 0; c < 60; c++) begin
            #1;
            if (oDmReq | oBusValid) begin
                if (reqs == waits) begin
                    iDmAck = oDmReq; iBusReady = oBusValid;
                    iDmRdata = rdata; iBusRdata = rdata;
                end
                reqs++;
            end
            if (oStall) stalls++;
            else done = 1;
            @(posedge clk);
            #2;
            iDmAck = 0; iBusReady = 0;
            if (done) break;
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL %s_bound: stall never released within 60 cycles", name);
        end
        clear_inputs();
        check({name, "_stall"}, 64'(stalls), 64'(exp_stall));
        check({name, "_req"}, 64'(reqs), 64'(exp_req));
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #3;
        check("rst_ctrl", {58'd0, oStall, oDmReq, oBusValid, oRegWrite, oErr, oDmWe}, 64'd0);
        check("rst_data", {28'd0, oWbData, oDest, oDmAddr}, 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2;

        run_op("alu_pass", 16'h1234, 16'h0, 4'd5, 1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h1234, 0, 0);
        run_op("load0", 16'h0040, 16'h0, 4'd3, 0, 1, 0, 1, 0, 0, 0, 16'hBEEF, 16'hBEEF, 2, 1);
        run_op("store3", 16'h0080, 16'hA5A5, 4'd6, 0, 0, 0, 0, 1, 0, 3, 16'h0, 16'h0, 5, 4);
        run_op("bus_rd", 16'h0107, 16'h0, 4'd7, 0, 0, 1, 0, 0, 0, 1, 16'h0F0F, 16'h0F0F, 3, 2);
        run_op("bus_wr", 16'h0122, 16'h5555, 4'd8, 0, 0, 0, 0, 0, 1, 0, 16'h0, 16'h0, 2, 1);
        run_op("b2b_a", 16'h0042, 16'h0, 4'd9, 0, 1, 0, 1, 0, 0, 0, 16'h1111, 16'h1111, 2, 1);
        run_op("b2b_b", 16'h0044, 16'h0, 4'd10, 0, 1, 0, 1, 0, 0, 2, 16'h2222, 16'h2222, 4, 3);
        // Memory op wins over a simultaneous bus write.
        run_op("prio", 16'h0050, 16'h7777, 4'd11, 0, 1, 0, 1, 0, 1, 0, 16'h3333, 16'h3333, 2, 1);

        // Reset in the middle of MEM_REQ.
        iAluOut = 16'h0060; iDest = 4'd4; iMemRead = 1; iMemtoReg = 1;
        dm_q.push_back({16'h0060, 1'b0, 16'h0});
        @(posedge clk);
        #3;
        check("rst_pre_req", {63'd0, oDmReq}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid", {60'd0, oDmReq, oStall, oRegWrite, oBusValid}, 64'd0);
        dm_q.delete();
        wb_q.delete();
        clear_inputs();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2;
        run_op("post_rst", 16'hCAFE, 16'h0, 4'd12, 1, 0, 0, 0, 0, 0, 0, 16'h0, 16'hCAFE, 0, 0);

`ifdef MEM_TIMEOUT_EN
        run_op("tmo", 16'h0090, 16'h0, 4'd13, 0, 1, 0, 1, 0, 0, 1000, 16'h0, 16'hDEAD, 5, 4);
        if (dm_q.size() != 0) void'(dm_q.pop_front());
        check("tmo_err", {63'd0, oErr}, 64'd1);
        run_op("tmo_next", 16'h0094, 16'h0, 4'd14, 0, 1, 0, 1, 0, 0, 0, 16'h4444, 16'h4444, 2, 1);
        check("tmo_err_sticky", {63'd0, oErr}, 64'd1);
`else
        check("err_idle", {63'd0, oErr}, 64'd0);
`endif

        repeat (3) @(posedge clk);
        #6;
        check("wb_q_empty", 64'(wb_q.size()), 64'd0);
        check("dm_q_empty", 64'(dm_q.size()), 64'd0);
        check("bus_q_empty", 64'(bus_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
